// File: rtl/fft_radix2_stream.sv
// Streaming radix-2 decimation-in-time FFT/IFFT over N = 2**LOG2N complex points.
// Samples are loaded bit-reversed, transformed in place one butterfly per cycle,
// then streamed out in natural order under valid/ready flow control.
module fft_radix2_stream #(
    parameter int LOG2N = 2,
    parameter int IN_W  = 8,
    parameter int OUT_W = 16,
    parameter int TW_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic             inverse_in,
    input  logic [IN_W-1:0]  real_in,
    input  logic [IN_W-1:0]  imag_in,
    output logic             valid_out,
    input  logic             ready_out,
    output logic [OUT_W-1:0] real_out,
    output logic [OUT_W-1:0] imag_out,
    output logic [LOG2N-1:0] index_out,
    output logic             last_out
);
    localparam int N     = 1 << LOG2N;
    localparam int PW    = OUT_W + TW_W + 1;      // full-precision complex product width
    localparam int SH    = TW_W - 2;              // twiddle fractional bits
    localparam int TW_SH = 30 - SH;               // Q1.30 master table down to Q1.SH
    localparam logic [LOG2N-1:0] IDX_LAST = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] BF_LAST  = LOG2N'(N / 2 - 1);
    localparam logic [2:0]       STG_DONE = 3'(LOG2N);

    typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_OUTPUT} state_t;

    function automatic logic [LOG2N-1:0] f_bitrev(input logic [LOG2N-1:0] n);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int b = 0; b < LOG2N; b++) r[b] = n[LOG2N-1-b];
        return r;
    endfunction

    // cos(2*pi*t/16) in Q1.30, t = 0..7 (the only angles any legal N needs)
    function automatic logic signed [31:0] f_cos_q30(input logic [2:0] t);
        case (t)
            3'd0:    return  32'sd1073741824;
            3'd1:    return  32'sd992008094;
            3'd2:    return  32'sd759250125;
            3'd3:    return  32'sd410903207;
            3'd4:    return  32'sd0;
            3'd5:    return -32'sd410903207;
            3'd6:    return -32'sd759250125;
            default: return -32'sd992008094;
        endcase
    endfunction

    // sin(2*pi*t/16) in Q1.30, t = 0..7
    function automatic logic signed [31:0] f_sin_q30(input logic [2:0] t);
        case (t)
            3'd0:    return 32'sd0;
            3'd1:    return 32'sd410903207;
            3'd2:    return 32'sd759250125;
            3'd3:    return 32'sd992008094;
            3'd4:    return 32'sd1073741824;
            3'd5:    return 32'sd992008094;
            3'd6:    return 32'sd759250125;
            default: return 32'sd410903207;
        endcase
    endfunction

    // Round-to-nearest from Q1.30 to Q1.(TW_W-2); valid for TW_W up to 31
    function automatic logic signed [TW_W-1:0] f_tw_round(input logic signed [31:0] q30);
        logic signed [32:0] v;
        v = $signed({q30[31], q30}) + (33'sd1 <<< (TW_SH - 1));
        return TW_W'(v >>> TW_SH);
    endfunction

    state_t                   r_state;
    logic [LOG2N-1:0]         r_cnt;
    logic [LOG2N-1:0]         r_bf;
    logic [2:0]               r_stg;
    logic                     r_inv;
    logic                     r_ready_in;
    logic                     r_valid_out;
    logic                     r_last_out;
    logic [LOG2N-1:0]         r_idx;
    logic [OUT_W-1:0]         r_real_out;
    logic [OUT_W-1:0]         r_imag_out;
    logic signed [OUT_W-1:0]  r_re [N];
    logic signed [OUT_W-1:0]  r_im [N];

    logic                     w_load_fire;
    logic                     w_bf_en;
    logic [LOG2N-1:0]         w_top;
    logic [LOG2N-1:0]         w_bot;
    logic [2:0]               w_t16;
    logic [LOG2N-1:0]         w_idx_nx;
    logic signed [OUT_W-1:0]  w_in_re, w_in_im;
    logic signed [TW_W-1:0]   w_wr, w_ws, w_wi;
    logic signed [PW-1:0]     w_bre_x, w_bim_x, w_wr_x, w_wi_x;
    logic signed [OUT_W-1:0]  w_p_re, w_p_im;
    logic signed [OUT_W-1:0]  w_top_re, w_top_im, w_bot_re, w_bot_im;

    assign w_load_fire = (r_state == S_LOAD) && valid_in && r_ready_in;
    assign w_bf_en     = (r_state == S_COMPUTE) && (r_stg != STG_DONE);
    assign w_idx_nx    = r_idx + LOG2N'(1);
    assign w_in_re     = {{(OUT_W-IN_W){real_in[IN_W-1]}}, real_in};
    assign w_in_im     = {{(OUT_W-IN_W){imag_in[IN_W-1]}}, imag_in};

    // Butterfly addressing: pair (top, bot) and twiddle index scaled to the 16-point table
    always_comb begin
        int s, j, span, k, base;
        s     = int'(r_stg);
        j     = int'(r_bf);
        span  = 1 << s;
        k     = j & (span - 1);
        base  = (j >> s) << (s + 1);
        w_top = LOG2N'(base | k);
        w_bot = LOG2N'(base | k | span);
        w_t16 = 3'((s <= 3) ? (k << (3 - s)) : 0);
    end

    // Twiddle and butterfly arithmetic; inverse mode conjugates W
    always_comb begin
        w_wr     = f_tw_round(f_cos_q30(w_t16));
        w_ws     = f_tw_round(f_sin_q30(w_t16));
        w_wi     = r_inv ? w_ws : -w_ws;
        w_bre_x  = {{(PW-OUT_W){r_re[w_bot][OUT_W-1]}}, r_re[w_bot]};
        w_bim_x  = {{(PW-OUT_W){r_im[w_bot][OUT_W-1]}}, r_im[w_bot]};
        w_wr_x   = {{(PW-TW_W){w_wr[TW_W-1]}}, w_wr};
        w_wi_x   = {{(PW-TW_W){w_wi[TW_W-1]}}, w_wi};
        w_p_re   = OUT_W'((w_bre_x * w_wr_x - w_bim_x * w_wi_x) >>> SH);
        w_p_im   = OUT_W'((w_bre_x * w_wi_x + w_bim_x * w_wr_x) >>> SH);
        w_top_re = r_re[w_top] + w_p_re;
        w_top_im = r_im[w_top] + w_p_im;
        w_bot_re = r_re[w_top] - w_p_re;
        w_bot_im = r_im[w_top] - w_p_im;
    end

    // Working buffer: bit-reversed sample writes in LOAD, in-place butterflies in COMPUTE
    always_ff @(posedge clk) begin
        if (w_load_fire) begin
            r_re[f_bitrev(r_cnt)] <= w_in_re;
            r_im[f_bitrev(r_cnt)] <= w_in_im;
        end else if (w_bf_en) begin
            r_re[w_top] <= w_top_re;
            r_im[w_top] <= w_top_im;
            r_re[w_bot] <= w_bot_re;
            r_im[w_bot] <= w_bot_im;
        end
    end

    // Frame sequencer LOAD -> COMPUTE -> OUTPUT with registered stream outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_LOAD;
            r_cnt       <= '0;
            r_bf        <= '0;
            r_stg       <= '0;
            r_inv       <= 1'b0;
            r_ready_in  <= 1'b1;
            r_valid_out <= 1'b0;
            r_last_out  <= 1'b0;
            r_idx       <= '0;
            r_real_out  <= '0;
            r_imag_out  <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_load_fire) begin
                        if (r_cnt == '0) r_inv <= inverse_in;
                        if (r_cnt == IDX_LAST) begin
                            r_cnt      <= '0;
                            r_ready_in <= 1'b0;
                            r_stg      <= '0;
                            r_bf       <= '0;
                            r_state    <= S_COMPUTE;
                        end else begin
                            r_cnt <= r_cnt + LOG2N'(1);
                        end
                    end
                end
                S_COMPUTE: begin
                    if (r_stg == STG_DONE) begin
                        r_state     <= S_OUTPUT;
                        r_valid_out <= 1'b1;
                        r_idx       <= '0;
                        r_last_out  <= 1'b0;
                        r_real_out  <= r_re[0];
                        r_imag_out  <= r_im[0];
                    end else if (r_bf == BF_LAST) begin
                        r_bf  <= '0;
                        r_stg <= r_stg + 3'd1;
                    end else begin
                        r_bf <= r_bf + LOG2N'(1);
                    end
                end
                S_OUTPUT: begin
                    if (ready_out) begin
                        if (r_idx == IDX_LAST) begin
                            r_valid_out <= 1'b0;
                            r_last_out  <= 1'b0;
                            r_ready_in  <= 1'b1;
                            r_state     <= S_LOAD;
                        end else begin
                            r_idx      <= w_idx_nx;
                            r_real_out <= r_re[w_idx_nx];
                            r_imag_out <= r_im[w_idx_nx];
                            r_last_out <= (w_idx_nx == IDX_LAST);
                        end
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    assign ready_in  = r_ready_in;
    assign valid_out = r_valid_out;
    assign last_out  = r_last_out;
    assign index_out = r_idx;
    assign real_out  = r_real_out;
    assign imag_out  = r_imag_out;

endmodule

// File: tb/tb_fft_radix2_stream.sv
// Bench for fft_radix2_stream: one instance each for N = 4, 8 and 16, each with its
// own driver, backpressure process, expected-bin queue and output monitor.
module tb_fft_radix2_stream;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit done_flag [3];

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int LG   = g + 2;
        localparam int NN   = 1 << LG;
        localparam int CLAT = LG * NN / 2 + 1;

        logic rst, valid_in, ready_in, inverse_in, valid_out, ready_out, last_out;
        logic [7:0]    real_in, imag_in;
        logic [15:0]   real_out, imag_out;
        logic [LG-1:0] index_out;

        int q_re[$], q_im[$], q_idx[$];
        int cyc = 0;
        int acc_cyc = 0;
        int rdy_mode = 0;
        int stall_left = 0;
        bit stall_done = 0;
        logic prev_stall, prev_valid;
        logic [15:0] h_re, h_im;
        logic [LG-1:0] h_idx;

        fft_radix2_stream #(.LOG2N(LG), .IN_W(8), .OUT_W(16), .TW_W(16)) u_dut (
            .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in),
            .inverse_in(inverse_in), .real_in(real_in), .imag_in(imag_in),
            .valid_out(valid_out), .ready_out(ready_out), .real_out(real_out),
            .imag_out(imag_out), .index_out(index_out), .last_out(last_out)
        );

        always @(posedge clk) cyc <= cyc + 1;

        function automatic int bitrev(input int n);
            int r = 0;
            for (int b = 0; b < LG; b++) if (n[b]) r |= 1 << (LG - 1 - b);
            return r;
        endfunction

        // Reference DFT: textbook iterative radix-2 with the stated fixed-point rules
        task automatic push_model(input int xr[16], input int xi[16], input bit inv);
            longint ar[16], ai[16];
            for (int n = 0; n < NN; n++) begin
                ar[bitrev(n)] = xr[n];
                ai[bitrev(n)] = xi[n];
            end
            for (int span = 1; span < NN; span *= 2)
                for (int base = 0; base < NN; base += 2 * span)
                    for (int k = 0; k < span; k++) begin
                        int t, top, bot;
                        real ang;
                        longint wr, ws, wi, pr, pim, a_r, a_i;
                        t   = k * (NN / (2 * span));
                        ang = 2.0 * 3.14159265358979323846 * t / NN;
                        wr  = longint'($rtoi($floor($cos(ang) * 16384.0 + 0.5)));
                        ws  = longint'($rtoi($floor($sin(ang) * 16384.0 + 0.5)));
                        wi  = inv ? ws : -ws;
                        top = base + k;
                        bot = top + span;
                        pr  = (ar[bot] * wr - ai[bot] * wi) >>> 14;
                        pim = (ar[bot] * wi + ai[bot] * wr) >>> 14;
                        a_r = ar[top];
                        a_i = ai[top];
                        ar[top] = a_r + pr;
                        ai[top] = a_i + pim;
                        ar[bot] = a_r - pr;
                        ai[bot] = a_i - pim;
                    end
            for (int k = 0; k < NN; k++) begin
                q_re.push_back(int'(ar[k]));
                q_im.push_back(int'(ai[k]));
                q_idx.push_back(k);
            end
        endtask

        task automatic push_const(input int re, input int im, input int idx);
            q_re.push_back(re);
            q_im.push_back(im);
            q_idx.push_back(idx);
        endtask

        task automatic send_frame(input int xr[16], input int xi[16], input bit inv,
                                  input bit gaps, input int cnt);
            for (int n = 0; n < cnt; n++) begin
                int w;
                bit acc;
                if (gaps) begin
                    valid_in = 1'b0;
                    repeat ($urandom_range(1, 2)) @(posedge clk);
                    #1;
                end
                valid_in   = 1'b1;
                real_in    = 8'(xr[n]);
                imag_in    = 8'(xi[n]);
                inverse_in = (n == 0) ? inv : ~inv;
                w = 0;
                acc = 1'b0;
                while (!acc && w < 300) begin
                    @(negedge clk);
                    acc = ready_in;
                    @(posedge clk);
                    #1;
                    w++;
                end
                if (!acc) check("ready_in_timeout", 0, 1);
                if (n == NN - 1) acc_cyc = cyc;
            end
            valid_in = 1'b0;
        endtask

        task automatic wait_drain();
            int w = 0;
            while (q_re.size() != 0 && w < 3000) begin
                @(posedge clk);
                w++;
            end
            repeat (3) @(posedge clk);
            #1;
            check("queue_drained", q_re.size(), 0);
        endtask

        // Downstream ready: always, random, or a 3-cycle stall on bin 1
        initial begin
            ready_out = 1'b1;
            forever begin
                @(posedge clk);
                #1;
                case (rdy_mode)
                    0: ready_out = 1'b1;
                    1: ready_out = ($urandom_range(0, 3) != 0);
                    default: begin
                        if (!stall_done && valid_out && index_out == 1) begin
                            ready_out  = 1'b0;
                            stall_left = 2;
                            stall_done = 1'b1;
                        end else if (stall_left > 0) begin
                            ready_out = 1'b0;
                            stall_left--;
                        end else begin
                            ready_out = 1'b1;
                        end
                    end
                endcase
            end
        end

        // Output monitor: pops the expected queue on every accepted bin
        always @(negedge clk) begin : mon
            int er, ei, ex;
            if (rst) begin
                prev_stall <= 1'b0;
                prev_valid <= 1'b0;
            end else begin
                if (valid_out) begin
                    check("ready_in_in_output", ready_in, 0);
                    if (prev_stall) begin
                        check("hold_re", real_out, h_re);
                        check("hold_im", imag_out, h_im);
                        check("hold_idx", index_out, h_idx);
                    end
                    if (!prev_valid) begin
                        check("first_bin_latency", cyc - acc_cyc, CLAT);
                        check("first_index", index_out, 0);
                    end
                    if (ready_out) begin
                        if (q_re.size() == 0) begin
                            check("unexpected_bin", 1, 0);
                        end else begin
                            er = q_re.pop_front();
                            ei = q_im.pop_front();
                            ex = q_idx.pop_front();
                            check("bin_re", $signed(real_out), er);
                            check("bin_im", $signed(imag_out), ei);
                            check("bin_index", index_out, ex);
                            check("last_out", last_out, (ex == NN - 1));
                        end
                    end
                end
                prev_stall <= valid_out && !ready_out;
                prev_valid <= valid_out;
                h_re  <= real_out;
                h_im  <= imag_out;
                h_idx <= index_out;
            end
        end

        // Stimulus: reset checks, directed frames for this size, then random frames
        initial begin
            int xr[16], xi[16];
            rst = 1'b1; valid_in = 1'b0; inverse_in = 1'b0; real_in = '0; imag_in = '0;
            repeat (3) @(posedge clk);
            @(negedge clk);
            check("rst_ready_in", ready_in, 1);
            check("rst_valid_out", valid_out, 0);
            check("rst_last_out", last_out, 0);
            check("rst_real_out", real_out, 0);
            check("rst_imag_out", imag_out, 0);
            check("rst_index_out", index_out, 0);
            @(posedge clk);
            #1 rst = 1'b0;

            if (LG == 2) begin
                xr = '{default: 0}; xi = '{default: 0};
                xr[0] = 10; xr[1] = 20; xr[2] = 30; xr[3] = 40;
                push_const(100, 0, 0); push_const(-20, 20, 1);
                push_const(-20, 0, 2); push_const(-20, -20, 3);
                send_frame(xr, xi, 1'b0, 1'b0, NN);

                xr[0] = 100; xr[1] = -20; xr[2] = -20; xr[3] = -20;
                xi[0] = 0;   xi[1] = 20;  xi[2] = 0;   xi[3] = -20;
                push_const(40, 0, 0); push_const(80, 0, 1);
                push_const(120, 0, 2); push_const(160, 0, 3);
                send_frame(xr, xi, 1'b1, 1'b0, NN);
                wait_drain();

                stall_done = 1'b0;
                rdy_mode = 2;
                xr = '{default: 0}; xi = '{default: 0};
                xr[0] = 10; xr[1] = 20; xr[2] = 30; xr[3] = 40;
                push_const(100, 0, 0); push_const(-20, 20, 1);
                push_const(-20, 0, 2); push_const(-20, -20, 3);
                send_frame(xr, xi, 1'b0, 1'b0, NN);
                wait_drain();
                rdy_mode = 0;

                send_frame(xr, xi, 1'b0, 1'b0, 2);
                rst = 1'b1;
                @(negedge clk);
                check("midrst_ready_in", ready_in, 1);
                check("midrst_valid_out", valid_out, 0);
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
                push_const(100, 0, 0); push_const(-20, 20, 1);
                push_const(-20, 0, 2); push_const(-20, -20, 3);
                send_frame(xr, xi, 1'b0, 1'b0, NN);
                wait_drain();
            end else if (LG == 3) begin
                xr = '{default: 0}; xi = '{default: 0};
                xr[0] = 64;
                for (int k = 0; k < NN; k++) push_const(64, 0, k);
                send_frame(xr, xi, 1'b0, 1'b0, NN);
                for (int n = 0; n < NN; n++) xr[n] = 127;
                push_const(1016, 0, 0);
                for (int k = 1; k < NN; k++) push_const(0, 0, k);
                send_frame(xr, xi, 1'b0, 1'b0, NN);
                wait_drain();
            end else begin
                xr = '{default: 0}; xi = '{default: 0};
                for (int n = 0; n < NN; n++) xr[n] = -128;
                for (int rep = 0; rep < 2; rep++) begin
                    push_const(-2048, 0, 0);
                    for (int k = 1; k < NN; k++) push_const(0, 0, k);
                    send_frame(xr, xi, 1'b0, rep[0], NN);
                end
                wait_drain();
            end

            rdy_mode = 1;
            for (int f = 0; f < 6; f++) begin
                for (int n = 0; n < 16; n++) begin
                    xr[n] = int'($urandom_range(0, 255)) - 128;
                    xi[n] = int'($urandom_range(0, 255)) - 128;
                end
                push_model(xr, xi, f[0]);
                send_frame(xr, xi, f[0], (f >= 3), NN);
            end
            wait_drain();
            rdy_mode = 0;
            done_flag[g] = 1'b1;
        end
    end

    initial begin
        int w = 0;
        while (!(done_flag[0] && done_flag[1] && done_flag[2]) && w < 60000) begin
            @(posedge clk);
            w++;
        end
        if (w >= 60000) check("global_timeout", 0, 1);
        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
